unsigned_int_to_single_sched: RTL

Round-robin scheduler that shares one pipelined `unsigned_int_to_single` converter between `N_REQ` requesters. It accepts 32-bit unsigned operands over per-requester valid/ready handshakes and issues at most one operand per cycle into the converter. It tags each issued operand with its requester ID, tracks it through the converter's fixed latency, and returns results in issue order through a credit-protected result FIFO with a valid/ready output. It sits between the integer producers and the float consumers of the datapath.

---
 rtl/unsigned_int_to_single_sched_if.sv | 41 ++++
 rtl/unsigned_int_to_single_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/unsigned_int_to_single_sched_if.sv
// unsigned_int_to_single_sched_if
//   Bundles the requester handshakes, the converter operand/result pair and
//   the result stream of unsigned_int_to_single_sched.
//   Parameter N_REQ : number of requesters (sets req_* widths and res_id width).
//   Signals:
//     req_valid [N_REQ]    operand pending, one bit per requester
//     req_ready [N_REQ]    one-hot grant back to the requesters
//     req_data  [32*N_REQ] operands, requester i at [32i+31:32i]
//     conv_a    [32]       registered operand to the converter
//     conv_z    [32]       converter result
//     res_valid/res_ready  result stream handshake
//     res_data  [32]       IEEE-754 single result
//     res_id    [ID_W]     requester that issued the result
//     busy                 results outstanding
//   Modports: slave = scheduler side, master = environment side.
interface unsigned_int_to_single_sched_if #(
   parameter int unsigned N_REQ = 4
);
   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [32*N_REQ-1:0] req_data;
   logic [31:0]         conv_a;
   logic [31:0]         conv_z;
   logic                res_valid;
   logic                res_ready;
   logic [31:0]         res_data;
   logic [ID_W-1:0]     res_id;
   logic                busy;

   modport slave (
      input  req_valid, req_data, conv_z, res_ready,
      output req_ready, conv_a, res_valid, res_data, res_id, busy
   );

   modport master (
      output req_valid, req_data, conv_z, res_ready,
      input  req_ready, conv_a, res_valid, res_data, res_id, busy
   );
endinterface

// File: rtl/unsigned_int_to_single_sched.sv
// unsigned_int_to_single_sched
//   Round-robin scheduler sharing one pipelined unsigned_int_to_single
//   converter between N_REQ requesters. Issues at most one operand per cycle,
//   tags it with the requester id, and returns results in issue order through
//   a credit-protected first-word-fall-through FIFO.
//   Parameters: N_REQ (2..8), LATENCY (>=1, conv_a -> conv_z cycles),
//               FIFO_DEPTH (power of two, >=1).
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     bus          unsigned_int_to_single_sched_if.slave (requests, converter,
//                  result stream, busy)
//     stat_issued  (UINT_SCHED_STATS_EN only) count of issued operands
//     stat_stall   (UINT_SCHED_STATS_EN only) cycles with a request pending
//                  but no credit
//   Optional feature macro: UINT_SCHED_STATS_EN.
module unsigned_int_to_single_sched #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned LATENCY    = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef UINT_SCHED_STATS_EN
   output logic [31:0] stat_issued,
   output logic [31:0] stat_stall,
`endif
   unsigned_int_to_single_sched_if.slave bus
);

   localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   // ---------------- credit / arbiter ----------------
   logic [CNT_W-1:0] outs;
   logic             credit;
   logic [ID_W-1:0]  last;
   logic [ID_W-1:0]  grant_id;
   logic [N_REQ-1:0] grant;
   logic             issue;
   logic             pop;
   int unsigned      idx;

   assign credit = (outs < DEPTH_C);

   // Search starts one past the last winner; credit and reset only mask the
   // result, so req_ready never depends on res_ready combinationally.
   always_comb begin
      grant    = '0;
      grant_id = last;
      issue    = 1'b0;
      idx      = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(last) + k) % N_REQ;
         if (!issue && bus.req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            issue      = 1'b1;
         end
      end
      if (!credit || !rst_n) begin
         grant    = '0;
         grant_id = last;
         issue    = 1'b0;
      end
   end

   assign bus.req_ready = grant;
   assign bus.busy      = (outs != '0);

   // ---------------- issue register and tag pipeline ----------------
   // Stage 0 is loaded together with conv_a; stage LATENCY lines up with conv_z.
   logic [31:0]     conv_a_q;
   logic [LATENCY:0] tag_v;
   logic [ID_W-1:0] tag_id [0:LATENCY];

   assign bus.conv_a = conv_a_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last     <= ID_W'(N_REQ - 1);
         conv_a_q <= '0;
         tag_v    <= '0;
         outs     <= '0;
      end else begin
         if (issue) begin
            last     <= grant_id;
            conv_a_q <= bus.req_data[32*grant_id +: 32];
         end else begin
            conv_a_q <= '0;
         end
         tag_v <= {tag_v[LATENCY-1:0], issue};
         case ({issue, pop})
            2'b10:   outs <= outs + 1'b1;
            2'b01:   outs <= outs - 1'b1;
            default: outs <= outs;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int unsigned k = 1; k <= LATENCY; k++) begin
         tag_id[k] <= tag_id[k-1];
      end
   end

   // ---------------- result FIFO ----------------
   logic             fifo_wr;
   logic [CNT_W-1:0] fifo_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [31:0]      mem_data [0:FIFO_DEPTH-1];
   logic [ID_W-1:0]  mem_id   [0:FIFO_DEPTH-1];

   assign fifo_wr       = tag_v[LATENCY];
   assign bus.res_valid = (fifo_cnt != '0);
   assign pop           = bus.res_valid & bus.res_ready;
   assign bus.res_data  = bus.res_valid ? mem_data[rd_ptr] : '0;
   assign bus.res_id    = bus.res_valid ? mem_id[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem_data[wr_ptr] <= bus.conv_z;
         mem_id[wr_ptr]   <= tag_id[LATENCY];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({fifo_wr, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

`ifdef UINT_SCHED_STATS_EN
   // ---------------- statistics ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue) begin
            stat_issued <= stat_issued + 32'd1;
         end
         if ((|bus.req_valid) && !credit) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule
